// File: rtl/mux_rr_reg.sv
// mux_rr_reg: N-input registered data mux with a round-robin arbiter.
// Each input channel and the output use a valid/ready handshake. The output
// register holds one beat, can drain and refill in the same cycle, and so
// sustains one beat per clock with one cycle of input-to-output latency.
module mux_rr_reg #(
    parameter int N  = 7,
    parameter int DW = 1
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [N-1:0]    out_sel,
    input  logic            out_ready
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          load;
    logic [N-1:0]  grant;
    logic [IW-1:0] gidx;

    // The output register can take a new beat when it is empty or draining.
    assign load = ~out_valid | out_ready;

    // Acceptance is held off while reset is asserted so no beat is taken then.
    assign in_ready = grant & {N{load & nreset}};

    generate
        if (N == 1) begin : g_single
            assign grant = in_valid;
            assign gidx  = '0;
        end else begin : g_rr
            logic [IW-1:0] last_q;
            logic [IW-1:0] cidx;
            logic          found;
            int            cand;

            // Pointer to the last granted channel; it moves only on an accepted
            // transfer, so stalls and idle cycles never skip a channel's turn.
            // Reset points it at N-1 so channel 0 is first in line.
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    last_q <= IW'(N - 1);
                end else if (load && (grant != '0)) begin
                    last_q <= gidx;
                end
            end

            // Scan from the channel after the last grant, wrapping, and pick
            // the first one that has a valid request.
            always_comb begin
                grant = '0;
                gidx  = '0;
                found = 1'b0;
                cand  = 0;
                cidx  = '0;
                for (int k = 1; k <= N; k++) begin
                    cand = int'(last_q) + k;
                    if (cand >= N) begin
                        cand = cand - N;
                    end
                    cidx = cand[IW-1:0];
                    if (!found && in_valid[cidx]) begin
                        found       = 1'b1;
                        grant[cidx] = 1'b1;
                        gidx        = cidx;
                    end
                end
            end
        end
    endgenerate

    // Output register: load the granted beat, empty when nothing is granted,
    // hold everything while the consumer stalls. Data and select keep their
    // old values when the register empties so only granted data ever lands.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            if (grant != '0) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(gidx)*DW +: DW];
                out_sel   <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Testbench for mux_rr_reg: directed scenarios on a 7x32 instance plus a
// randomized run on 7x32, 2x1 and 1x32 instances against a behavioural model.
module tb_mux_rr_reg;

    logic         clk = 1'b0;
    logic         nreset;
    logic [6:0]   iv   [3];
    logic [223:0] id   [3];
    logic         ordy [3];

    logic [6:0]  a_ir, a_os;
    logic        a_ov;
    logic [31:0] a_od;
    logic [1:0]  b_ir, b_os;
    logic        b_ov, b_od;
    logic        c_ir, c_os, c_ov;
    logic [31:0] c_od;

    logic [6:0]  ir [3];
    logic [6:0]  os [3];
    logic        ov [3];
    logic [31:0] od [3];

    int tests = 0;
    int fails = 0;

    localparam int NK  [3] = '{7, 2, 1};
    localparam int DWK [3] = '{32, 1, 32};

    always #5 clk = ~clk;

    mux_rr_reg #(.N(7), .DW(32)) dut_a (
        .clk(clk), .nreset(nreset), .in_valid(iv[0]), .in_data(id[0]),
        .in_ready(a_ir), .out_valid(a_ov), .out_data(a_od), .out_sel(a_os),
        .out_ready(ordy[0])
    );

    mux_rr_reg #(.N(2), .DW(1)) dut_b (
        .clk(clk), .nreset(nreset), .in_valid(iv[1][1:0]), .in_data(id[1][1:0]),
        .in_ready(b_ir), .out_valid(b_ov), .out_data(b_od), .out_sel(b_os),
        .out_ready(ordy[1])
    );

    mux_rr_reg #(.N(1), .DW(32)) dut_c (
        .clk(clk), .nreset(nreset), .in_valid(iv[2][0:0]), .in_data(id[2][31:0]),
        .in_ready(c_ir), .out_valid(c_ov), .out_data(c_od), .out_sel(c_os),
        .out_ready(ordy[2])
    );

    always_comb begin
        ir[0] = a_ir;           os[0] = a_os;           ov[0] = a_ov; od[0] = a_od;
        ir[1] = {5'b0, b_ir};   os[1] = {5'b0, b_os};   ov[1] = b_ov; od[1] = {31'b0, b_od};
        ir[2] = {6'b0, c_ir};   os[2] = {6'b0, c_os};   ov[2] = c_ov; od[2] = c_od;
    end

    task automatic do_reset();
        nreset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = '0; id[k] = '0; ordy[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 7; i++) id[0][i*32 +: 32] = 32'(i);
    endtask

    task automatic test_reset();
        nreset   = 1'b0;
        iv[0]    = 7'($urandom);
        id[0]    = {7{$urandom}};
        ordy[0]  = 1'($urandom);
        repeat (3) @(negedge clk);
        #1;
        tests++; if (a_ov !== 1'b0)   begin fails++; $display("FAIL reset_out_valid got %0b want 0", a_ov); end
        tests++; if (a_od !== 32'd0)  begin fails++; $display("FAIL reset_out_data got %h want 0", a_od); end
        tests++; if (a_os !== 7'd0)   begin fails++; $display("FAIL reset_out_sel got %b want 0", a_os); end
        tests++; if (a_ir !== 7'd0)   begin fails++; $display("FAIL reset_in_ready got %b want 0", a_ir); end
        @(negedge clk);
        nreset  = 1'b1;
        iv[0]   = 7'b0000100;
        id[0]   = {7{$urandom}};
        id[0][2*32 +: 32] = 32'h1;
        ordy[0] = 1'b1;
        #1;
        tests++; if (a_ir !== 7'b0000100) begin fails++; $display("FAIL reset_first_ready got %b want 0000100", a_ir); end
        @(posedge clk); #1;
        tests++; if (a_ov !== 1'b1)       begin fails++; $display("FAIL reset_first_valid got %0b want 1", a_ov); end
        tests++; if (a_od !== 32'h1)      begin fails++; $display("FAIL reset_first_data got %h want 1", a_od); end
        tests++; if (a_os !== 7'b0000100) begin fails++; $display("FAIL reset_first_sel got %b want 0000100", a_os); end
    endtask

    task automatic test_round_robin();
        do_reset();
        iv[0] = 7'h7f; set_ramp(); ordy[0] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            #1;
            tests++;
            if (a_ir !== 7'(1 << (c % 7))) begin
                fails++; $display("FAIL rr_ready beat %0d got %b want %b", c, a_ir, 7'(1 << (c % 7)));
            end
            @(posedge clk); #1;
            tests++;
            if (a_ov !== 1'b1 || a_od !== 32'(c % 7) || a_os !== 7'(1 << (c % 7))) begin
                fails++; $display("FAIL rr_beat %0d got v=%0b d=%0d s=%b want d=%0d", c, a_ov, a_od, a_os, c % 7);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        do_reset();
        iv[0] = 7'h7f; set_ramp(); ordy[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1 ordy[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            tests++;
            if (a_ir !== 7'd0 || a_ov !== 1'b1 || a_od !== 32'h3 || a_os !== 7'b0001000) begin
                fails++; $display("FAIL stall_hold cycle %0d got r=%b v=%0b d=%h s=%b want r=0 v=1 d=3", c, a_ir, a_ov, a_od, a_os);
            end
        end
        ordy[0] = 1'b1;
        #1;
        tests++; if (a_ir !== 7'b0010000) begin fails++; $display("FAIL stall_resume_ready got %b want 0010000", a_ir); end
        @(posedge clk); #1;
        tests++;
        if (a_od !== 32'h4 || a_os !== 7'b0010000) begin
            fails++; $display("FAIL stall_resume_beat got d=%h s=%b want d=4 s=0010000", a_od, a_os);
        end
    endtask

    task automatic test_sparse_wrap();
        int exp_seq [3] = '{0, 5, 0};
        do_reset();
        iv[0] = 7'b1000000; set_ramp(); ordy[0] = 1'b1;
        @(posedge clk); #1;
        tests++; if (a_od !== 32'h6) begin fails++; $display("FAIL wrap_prime got %h want 6", a_od); end
        iv[0] = 7'b0100001;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (a_ir !== 7'(1 << exp_seq[c])) begin
                fails++; $display("FAIL wrap_ready step %0d got %b want %b", c, a_ir, 7'(1 << exp_seq[c]));
            end
            @(posedge clk); #1;
            tests++;
            if (a_od !== 32'(exp_seq[c]) || a_ov !== 1'b1) begin
                fails++; $display("FAIL wrap_beat step %0d got v=%0b d=%h want d=%0d", c, a_ov, a_od, exp_seq[c]);
            end
        end
        iv[0] = 7'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (a_ov !== 1'b0 || a_os !== 7'b0000001 || a_od !== 32'h0) begin
            fails++; $display("FAIL wrap_idle got v=%0b d=%h s=%b want v=0 d=0 s=0000001", a_ov, a_od, a_os);
        end
        iv[0] = 7'b0100001;
        #1;
        tests++; if (a_ir !== 7'b0100000) begin fails++; $display("FAIL wrap_after_idle got %b want 0100000", a_ir); end
        @(posedge clk); #1;
        tests++; if (a_od !== 32'h5) begin fails++; $display("FAIL wrap_after_idle_beat got %h want 5", a_od); end
    endtask

    task automatic test_async_reset();
        do_reset();
        iv[0] = 7'h7f; set_ramp(); ordy[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 ordy[0] = 1'b0;
        @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        tests++;
        if (a_ov !== 1'b0 || a_ir !== 7'd0 || a_od !== 32'd0 || a_os !== 7'd0) begin
            fails++; $display("FAIL async_reset got v=%0b r=%b d=%h s=%b want all 0", a_ov, a_ir, a_od, a_os);
        end
        @(negedge clk);
        nreset = 1'b1;
        #1;
        tests++; if (a_ir !== 7'b0000001) begin fails++; $display("FAIL async_reset_ready got %b want 0000001", a_ir); end
        @(posedge clk); #1;
        tests++;
        if (a_ov !== 1'b1 || a_os !== 7'b0000001) begin
            fails++; $display("FAIL async_reset_first got v=%0b s=%b want v=1 s=0000001", a_ov, a_os);
        end
    endtask

    task automatic test_random();
        int           mlast [3];
        bit           mov   [3];
        logic [31:0]  mod   [3];
        logic [6:0]   mos   [3];
        int           waitc [3][7];
        logic [6:0]   acc   [3];
        int           n, dw, g, c;
        bit           load;
        logic [6:0]   exp_ir;
        logic [31:0]  mask;
        logic [223:0] sh;

        do_reset();
        for (int k = 0; k < 3; k++) begin
            mlast[k] = NK[k] - 1; mov[k] = 1'b0; mod[k] = '0; mos[k] = '0; acc[k] = '0;
            for (int i = 0; i < 7; i++) waitc[k][i] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            // producers: drop accepted requests, raise new ones, rarely withdraw
            for (int k = 0; k < 3; k++) begin
                n = NK[k]; dw = DWK[k];
                for (int i = 0; i < n; i++) begin
                    if (acc[k][i]) iv[k][i] = 1'b0;
                    if (!iv[k][i]) begin
                        if ($urandom_range(9) < 4) begin
                            iv[k][i] = 1'b1;
                            for (int b = 0; b < dw; b++) id[k][i*dw + b] = 1'($urandom);
                        end
                    end else if ($urandom_range(31) == 0) begin
                        iv[k][i] = 1'b0;
                    end
                end
                ordy[k] = ($urandom_range(9) < 7);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                n = NK[k]; dw = DWK[k];
                mask = (dw == 32) ? 32'hffff_ffff : 32'((1 << dw) - 1);
                g = -1;
                for (int j = 1; j <= n; j++) begin
                    c = (mlast[k] + j) % n;
                    if (g < 0 && iv[k][c]) g = c;
                end
                load   = !mov[k] || ordy[k];
                exp_ir = (g >= 0 && load) ? 7'(1 << g) : 7'd0;
                tests++;
                if (ir[k] !== exp_ir) begin
                    fails++; $display("FAIL rand_ready inst %0d cyc %0d got %b want %b", k, cyc, ir[k], exp_ir);
                end
                tests++;
                if ({ov[k], od[k], os[k]} !== {mov[k], mod[k], mos[k]}) begin
                    fails++; $display("FAIL rand_out inst %0d cyc %0d got v=%0b d=%h s=%b want v=%0b d=%h s=%b",
                                      k, cyc, ov[k], od[k], os[k], mov[k], mod[k], mos[k]);
                end
                acc[k] = ir[k] & iv[k];
                if (g >= 0 && load) begin
                    for (int i = 0; i < n; i++) begin
                        if (i == g || !iv[k][i]) begin
                            waitc[k][i] = 0;
                        end else begin
                            waitc[k][i]++;
                            tests++;
                            if (waitc[k][i] > n - 1) begin
                                fails++; $display("FAIL rand_wait inst %0d ch %0d got %0d beats want <= %0d", k, i, waitc[k][i], n - 1);
                            end
                        end
                    end
                    sh       = id[k] >> (g * dw);
                    mov[k]   = 1'b1;
                    mod[k]   = sh[31:0] & mask;
                    mos[k]   = 7'(1 << g);
                    mlast[k] = g;
                end else begin
                    for (int i = 0; i < n; i++) if (!iv[k][i]) waitc[k][i] = 0;
                    if (load) mov[k] = 1'b0;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        nreset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = '0; id[k] = '0; ordy[k] = 1'b0;
        end
        test_reset();
        test_round_robin();
        test_stall();
        test_sparse_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
